// File: rtl/ctrl_msg_if.sv
// rtl/ctrl_msg_if.sv - host command, loopback, acknowledgement and control-stream signals of ctrl_msg_scheduler
interface ctrl_msg_if #(
    parameter int DATA_WIDTH    = 64,
    parameter int CORE_ID_WIDTH = 4,
    parameter int CORE_COUNT    = 16
);
    logic                     host_cmd_valid;
    logic                     host_cmd_ready;
    logic                     host_cmd_all;
    logic [CORE_ID_WIDTH-1:0] host_cmd_core;
    logic [DATA_WIDTH-1:0]    lb_tdata;
    logic [CORE_ID_WIDTH-1:0] lb_tdest;
    logic                     lb_tvalid;
    logic                     lb_tready;
    logic                     core_ack_valid;
    logic [CORE_ID_WIDTH-1:0] core_ack_core;
    logic [DATA_WIDTH-1:0]    ctrl_m_axis_tdata;
    logic [CORE_ID_WIDTH-1:0] ctrl_m_axis_tdest;
    logic                     ctrl_m_axis_tvalid;
    logic                     ctrl_m_axis_tready;
    logic                     ctrl_m_axis_tlast;
    logic [CORE_COUNT-1:0]    reset_pending;
    logic                     seq_busy;
    logic                     timeout_err;

    modport slave (
        input  host_cmd_valid, host_cmd_all, host_cmd_core,
        input  lb_tdata, lb_tdest, lb_tvalid,
        input  core_ack_valid, core_ack_core,
        input  ctrl_m_axis_tready,
        output host_cmd_ready, lb_tready,
        output ctrl_m_axis_tdata, ctrl_m_axis_tdest, ctrl_m_axis_tvalid, ctrl_m_axis_tlast,
        output reset_pending, seq_busy, timeout_err
    );

    modport master (
        output host_cmd_valid, host_cmd_all, host_cmd_core,
        output lb_tdata, lb_tdest, lb_tvalid,
        output core_ack_valid, core_ack_core,
        output ctrl_m_axis_tready,
        input  host_cmd_ready, lb_tready,
        input  ctrl_m_axis_tdata, ctrl_m_axis_tdest, ctrl_m_axis_tvalid, ctrl_m_axis_tlast,
        input  reset_pending, seq_busy, timeout_err
    );
endinterface

// File: rtl/ctrl_msg_scheduler.sv
// rtl/ctrl_msg_scheduler.sv - core-reset sequencer and loopback arbiter; ack timeout enabled by CTRL_SCHED_TIMEOUT_EN
module ctrl_msg_scheduler #(
    parameter int CORE_COUNT    = 16,
    parameter int DATA_WIDTH    = 64,
    parameter int CORE_ID_WIDTH = $clog2(CORE_COUNT),
    parameter int LVL1_SW_PORTS = CORE_COUNT,
    parameter int STARTUP_RESET = 1,
    parameter int ACK_TIMEOUT   = 4096
) (
    input  logic      clk,
    input  logic      rst_n,
    ctrl_msg_if.slave bus
);
    localparam int LVL2      = CORE_COUNT / LVL1_SW_PORTS;
    localparam int LVL1_BITS = $clog2(LVL1_SW_PORTS);
    localparam logic [DATA_WIDTH-1:0] RESET_MSG = DATA_WIDTH'(64'hFFFF_FFFF_FFFF_FFFE);

    typedef enum logic [1:0] {IDLE, SWEEP, SINGLE} state_t;

    state_t                   state_q, state_d;
    logic                     started_q, started_d;
    logic [CORE_ID_WIDTH:0]   cnt_q, cnt_d;
    logic [CORE_ID_WIDTH-1:0] core_q, core_d;
    logic                     tvalid_q, tvalid_d;
    logic [DATA_WIDTH-1:0]    tdata_q, tdata_d;
    logic [CORE_ID_WIDTH-1:0] tdest_q, tdest_d;
    logic [CORE_COUNT-1:0]    pending_q, pending_d;

    logic                     load_en, load, load_reset, host_rdy, lb_rdy, tmo_fire;
    logic [CORE_ID_WIDTH-1:0] load_dest, sweep_dest, fire_core, cnt_idx;
    logic [DATA_WIDTH-1:0]    load_data;

    assign cnt_idx = cnt_q[CORE_ID_WIDTH-1:0];

    // Sweep walks the switch tree column-wise so consecutive resets land on different first-level ports.
    generate
        if (LVL2 == 1 || LVL1_BITS == 0) begin : g_flat
            assign sweep_dest = cnt_idx;
        end else begin : g_rot
            assign sweep_dest = {cnt_idx[LVL1_BITS-1:0], cnt_idx[CORE_ID_WIDTH-1:LVL1_BITS]};
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        started_d  = 1'b1;
        cnt_d      = cnt_q;
        core_d     = core_q;
        tvalid_d   = tvalid_q;
        tdata_d    = tdata_q;
        tdest_d    = tdest_q;
        host_rdy   = 1'b0;
        lb_rdy     = 1'b0;
        load       = 1'b0;
        load_reset = 1'b0;
        load_dest  = '0;
        load_data  = '0;
        load_en    = !tvalid_q || bus.ctrl_m_axis_tready;

        case (state_q)
            IDLE: begin
                if (!started_q) begin
                    if (STARTUP_RESET != 0) begin
                        state_d = SWEEP;
                        cnt_d   = '0;
                    end
                end else if (tmo_fire) begin
                    state_d = SINGLE;
                    core_d  = fire_core;
                end else if (bus.host_cmd_valid) begin
                    host_rdy = load_en;
                    if (load_en) begin
                        if (bus.host_cmd_all) begin
                            state_d = SWEEP;
                            cnt_d   = '0;
                        end else begin
                            state_d = SINGLE;
                            core_d  = bus.host_cmd_core;
                        end
                    end
                end else begin
                    lb_rdy = load_en && !pending_q[bus.lb_tdest];
                    if (lb_rdy && bus.lb_tvalid) begin
                        load      = 1'b1;
                        load_dest = bus.lb_tdest;
                        load_data = {8'd0, bus.lb_tdata[DATA_WIDTH-9:0]};
                    end
                end
            end
            SWEEP: begin
                if (load_en) begin
                    load       = 1'b1;
                    load_reset = 1'b1;
                    load_dest  = sweep_dest;
                    load_data  = RESET_MSG;
                    cnt_d      = cnt_q + 1'b1;
                    if (cnt_q == (CORE_ID_WIDTH+1)'(CORE_COUNT-1)) state_d = IDLE;
                end
            end
            SINGLE: begin
                if (load_en) begin
                    load       = 1'b1;
                    load_reset = 1'b1;
                    load_dest  = core_q;
                    load_data  = RESET_MSG;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load_en) begin
            tvalid_d = load;
            if (load) begin
                tdata_d = load_data;
                tdest_d = load_dest;
            end
        end

        // A reset loading in the same cycle as an ack for that core keeps the core pending.
        pending_d = pending_q;
        if (bus.core_ack_valid) pending_d[bus.core_ack_core] = 1'b0;
        if (load_reset) pending_d[load_dest] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            started_q <= 1'b0;
            cnt_q     <= '0;
            core_q    <= '0;
            tvalid_q  <= 1'b0;
            tdata_q   <= '0;
            tdest_q   <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            started_q <= started_d;
            cnt_q     <= cnt_d;
            core_q    <= core_d;
            tvalid_q  <= tvalid_d;
            tdata_q   <= tdata_d;
            tdest_q   <= tdest_d;
            pending_q <= pending_d;
        end
    end

`ifdef CTRL_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          terr_q, terr_d;
    logic          tmo_hit, ack_acc;

    assign tmo_hit  = (tmo_cnt_q == TW'(ACK_TIMEOUT - 1));
    assign ack_acc  = bus.core_ack_valid && pending_q[bus.core_ack_core];
    assign tmo_fire = tmo_hit && (state_q == IDLE) && started_q && (|pending_q);

    always_comb begin
        fire_core = '0;
        for (int i = CORE_COUNT - 1; i >= 0; i--) begin
            if (pending_q[i]) fire_core = CORE_ID_WIDTH'(i);
        end
    end

    // Counter parks at its limit outside IDLE so the retry fires as soon as the sequencer is free.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        terr_d    = terr_q;
        if (tmo_fire || ack_acc || !(|pending_q)) tmo_cnt_d = '0;
        else if (!tmo_hit) tmo_cnt_d = tmo_cnt_q + 1'b1;
        if (tmo_fire) terr_d = 1'b1;
        else if (bus.host_cmd_valid && host_rdy) terr_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
            terr_q    <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            terr_q    <= terr_d;
        end
    end

    assign bus.timeout_err = terr_q;
`else
    assign tmo_fire        = 1'b0;
    assign fire_core       = '0;
    assign bus.timeout_err = 1'b0;
`endif

    assign bus.host_cmd_ready     = host_rdy;
    assign bus.lb_tready          = lb_rdy;
    assign bus.ctrl_m_axis_tdata  = tdata_q;
    assign bus.ctrl_m_axis_tdest  = tdest_q;
    assign bus.ctrl_m_axis_tvalid = tvalid_q;
    assign bus.ctrl_m_axis_tlast  = 1'b1;
    assign bus.reset_pending      = pending_q;
    assign bus.seq_busy           = (state_q != IDLE);
endmodule

// File: tb/tb_ctrl_msg_scheduler.sv
// tb/tb_ctrl_msg_scheduler.sv - randomized self-checking bench for ctrl_msg_scheduler
module tb_ctrl_msg_scheduler;
    localparam int CC = 16, DW = 64, CW = 4, L1 = 4, AT = 8;
    localparam logic [DW-1:0] RST_MSG = 64'hFFFF_FFFF_FFFF_FFFE;

    typedef struct packed {
        logic [CW-1:0] dest;
        logic [DW-1:0] data;
    } msg_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    ctrl_msg_if #(.DATA_WIDTH(DW), .CORE_ID_WIDTH(CW), .CORE_COUNT(CC)) bus();

    ctrl_msg_scheduler #(
        .CORE_COUNT(CC), .DATA_WIDTH(DW), .CORE_ID_WIDTH(CW),
        .LVL1_SW_PORTS(L1), .STARTUP_RESET(1), .ACK_TIMEOUT(AT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int n_cmp = 0, n_err = 0, cyc = 0, rdy_mode = 0;
    msg_t obs_q[$], exp_q[$];
    int obs_cyc[$];
    logic [CC-1:0] m_pend;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk)
        if (rst_n && bus.ctrl_m_axis_tvalid && bus.ctrl_m_axis_tready) begin
            obs_q.push_back({bus.ctrl_m_axis_tdest, bus.ctrl_m_axis_tdata});
            obs_cyc.push_back(cyc);
        end

    initial begin
        bus.ctrl_m_axis_tready = 1'b1;
        forever begin
            @(posedge clk); #1;
            bus.ctrl_m_axis_tready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Sweep order: column-major walk over an L1 x (CC/L1) switch grid.
    function automatic logic [CW-1:0] sweep_ref(input int c);
        return CW'((c % L1) * (CC / L1) + c / L1);
    endfunction

    function automatic logic [DW-1:0] lb_ref(input logic [DW-1:0] d);
        return d & 64'h00FF_FFFF_FFFF_FFFF;
    endfunction

    function automatic msg_t mk(input logic [CW-1:0] dest, input logic [DW-1:0] data);
        msg_t m;
        m.dest = dest;
        m.data = data;
        return m;
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic push_sweep();
        for (int c = 0; c < CC; c++) exp_q.push_back(mk(sweep_ref(c), RST_MSG));
    endtask

    task automatic drain();
        int quiet;
        quiet = 0;
        for (int i = 0; i < 400 && quiet < 3; i++) begin
            @(negedge clk);
            if (!bus.ctrl_m_axis_tvalid && !bus.seq_busy) quiet++;
            else quiet = 0;
        end
        if (quiet < 3) chk("drain_timeout", 0, 1);
        tick();
    endtask

    task automatic cmp_msgs(input string tag);
        msg_t o, e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() == 0) chk({tag, "_missing"}, 0, 1);
            else begin
                o = obs_q.pop_front();
                chk({tag, "_dest"}, 64'(o.dest), 64'(e.dest));
                chk({tag, "_data"}, o.data, e.data);
            end
        end
        chk({tag, "_extra"}, 64'(obs_q.size()), 0);
        obs_q.delete();
        obs_cyc.delete();
    endtask

    task automatic host_cmd(input logic all, input logic [CW-1:0] core);
        bit done;
        done = 0;
        bus.host_cmd_valid = 1'b1;
        bus.host_cmd_all   = all;
        bus.host_cmd_core  = core;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            done = bus.host_cmd_ready;
            tick();
        end
        bus.host_cmd_valid = 1'b0;
        if (!done) chk("host_accept_timeout", 0, 1);
    endtask

    task automatic ack(input logic [CW-1:0] c);
        bus.core_ack_valid = 1'b1;
        bus.core_ack_core  = c;
        tick();
        bus.core_ack_valid = 1'b0;
    endtask

    task automatic lb_push(input logic [CW-1:0] d, input logic [DW-1:0] data);
        bit done;
        done = 0;
        bus.lb_tvalid = 1'b1;
        bus.lb_tdest  = d;
        bus.lb_tdata  = data;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            done = bus.lb_tready;
            tick();
        end
        bus.lb_tvalid = 1'b0;
        if (!done) chk("lb_accept_timeout", 0, 1);
    endtask

    initial begin
        int kind, waited;
        bit h_on, l_on, h_acc, l_acc, got;
        logic [CW-1:0] c, sd;
        logic [DW-1:0] d, d2, sdat;
        msg_t o;

        bus.host_cmd_valid = 0; bus.host_cmd_all = 0; bus.host_cmd_core = '0;
        bus.lb_tvalid = 0; bus.lb_tdest = '0; bus.lb_tdata = '0;
        bus.core_ack_valid = 0; bus.core_ack_core = '0;

        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_tvalid", 64'(bus.ctrl_m_axis_tvalid), 0);
        chk("rst_tlast", 64'(bus.ctrl_m_axis_tlast), 1);
        chk("rst_pending", 64'(bus.reset_pending), 0);
        chk("rst_busy", 64'(bus.seq_busy), 0);
        chk("rst_host_ready", 64'(bus.host_cmd_ready), 0);
        chk("rst_lb_ready", 64'(bus.lb_tready), 0);
        chk("rst_timeout_err", 64'(bus.timeout_err), 0);
        @(posedge clk); #1 rst_n = 1'b1;

`ifndef CTRL_SCHED_TIMEOUT_EN
        // Startup sweep with a stall in the middle.
        push_sweep();
        for (int i = 0; i < 100 && obs_q.size() < 6; i++) @(negedge clk);
        rdy_mode = 2;
        tick();
        @(negedge clk);
        chk("bp_valid", 64'(bus.ctrl_m_axis_tvalid), 1);
        sd   = bus.ctrl_m_axis_tdest;
        sdat = bus.ctrl_m_axis_tdata;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", 64'(bus.ctrl_m_axis_tvalid), 1);
            chk("bp_hold_dest", 64'(bus.ctrl_m_axis_tdest), 64'(sd));
            chk("bp_hold_data", bus.ctrl_m_axis_tdata, sdat);
        end
        rdy_mode = 1;
        drain();
        cmp_msgs("sweep");
        chk("sweep_pending", 64'(bus.reset_pending), 64'hFFFF);
        chk("sweep_busy", 64'(bus.seq_busy), 0);
        chk("tlast", 64'(bus.ctrl_m_axis_tlast), 1);
        m_pend = '1;

        // Loopback to an unacknowledged core stalls the stream.
        rdy_mode = 0;
        for (int i = 0; i < 15; i++) ack(CW'(i));
        m_pend = 16'h8000;
        d = {$urandom, $urandom};
        d2 = {$urandom, $urandom};
        bus.lb_tvalid = 1'b1; bus.lb_tdest = 4'd15; bus.lb_tdata = d;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("blocked_lb_ready", 64'(bus.lb_tready), 0);
            tick();
        end
        ack(4'd15);
        m_pend = '0;
        lb_push(4'd15, d);
        lb_push(4'd3, d2);
        exp_q.push_back(mk(4'd15, lb_ref(d)));
        exp_q.push_back(mk(4'd3, lb_ref(d2)));
        drain();
        cmp_msgs("blocked");
        chk("blocked_pending", 64'(bus.reset_pending), 0);

        // Host single reset arriving together with a loopback descriptor.
        d = {$urandom, $urandom};
        bus.host_cmd_valid = 1; bus.host_cmd_all = 0; bus.host_cmd_core = 4'd7;
        bus.lb_tvalid = 1; bus.lb_tdest = 4'd0; bus.lb_tdata = d;
        h_on = 1; l_on = 1;
        @(negedge clk);
        chk("prio_lb_ready_first", 64'(bus.lb_tready), 0);
        for (int i = 0; i < 50 && (h_on || l_on); i++) begin
            if (i > 0) @(negedge clk);
            h_acc = h_on && bus.host_cmd_ready;
            l_acc = l_on && bus.lb_tready;
            tick();
            if (h_acc) begin bus.host_cmd_valid = 0; h_on = 0; end
            if (l_acc) begin bus.lb_tvalid = 0; l_on = 0; end
        end
        if (h_on || l_on) chk("prio_accept_timeout", 0, 1);
        exp_q.push_back(mk(4'd7, RST_MSG));
        exp_q.push_back(mk(4'd0, lb_ref(d)));
        drain();
        if (obs_cyc.size() == 2) chk("prio_gap", 64'(obs_cyc[1] - obs_cyc[0]), 1);
        else chk("prio_count", 64'(obs_cyc.size()), 2);
        cmp_msgs("prio");
        m_pend[7] = 1'b1;

        // Ack for core 2 in the same cycle its reset loads.
        host_cmd(1'b0, 4'd2);
        ack(4'd2);
        exp_q.push_back(mk(4'd2, RST_MSG));
        m_pend[2] = 1'b1;
        drain();
        chk("same_cycle_bit2", 64'(bus.reset_pending[2]), 1);
        chk("same_cycle_pending", 64'(bus.reset_pending), 64'(m_pend));
        cmp_msgs("same_cycle");

        // Random rounds against the transaction-level model.
        rdy_mode = 1;
        for (int r = 0; r < 40; r++) begin
            kind = $urandom_range(0, 19);
            c = CW'($urandom_range(0, CC - 1));
            d = {$urandom, $urandom};
            if (kind < 6) begin
                host_cmd(1'b0, c);
                exp_q.push_back(mk(c, RST_MSG));
                m_pend[c] = 1'b1;
            end else if (kind < 12) begin
                ack(c);
                m_pend[c] = 1'b0;
            end else if (kind < 19) begin
                if (m_pend[c]) begin
                    bus.lb_tvalid = 1; bus.lb_tdest = c; bus.lb_tdata = d;
                    for (int k = 0; k < 3; k++) begin
                        @(negedge clk);
                        chk("rand_lb_blocked", 64'(bus.lb_tready), 0);
                        tick();
                    end
                    ack(c);
                    m_pend[c] = 1'b0;
                end
                lb_push(c, d);
                exp_q.push_back(mk(c, lb_ref(d)));
            end else begin
                host_cmd(1'b1, '0);
                push_sweep();
                m_pend = '1;
            end
            drain();
            chk("rand_pending", 64'(bus.reset_pending), 64'(m_pend));
            chk("rand_timeout_err", 64'(bus.timeout_err), 0);
            cmp_msgs("rand");
        end
`else
        // Ack timeout: core 5 never acknowledges.
        repeat (60) tick();
        for (int i = 0; i < CC; i++) if (i != 5) ack(CW'(i));
        host_cmd(1'b0, 4'd0);
        @(negedge clk);
        chk("tmo_clear_on_host", 64'(bus.timeout_err), 0);
        tick();
        tick();
        ack(4'd0);
        obs_q.delete();
        obs_cyc.delete();
        waited = 0;
        for (int i = 0; i < 100 && !bus.timeout_err; i++) begin @(negedge clk); waited++; end
        chk("tmo_set", 64'(bus.timeout_err), 1);
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin @(negedge clk); got = (obs_q.size() > 0); end
        if (got) begin
            o = obs_q.pop_front();
            chk("tmo_resend_dest", 64'(o.dest), 5);
            chk("tmo_resend_data", o.data, RST_MSG);
        end else chk("tmo_resend_missing", 0, 1);
        chk("tmo_pending5", 64'(bus.reset_pending[5]), 1);
        tick();
        host_cmd(1'b0, 4'd5);
        @(negedge clk);
        chk("tmo_clear_again", 64'(bus.timeout_err), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ctrl_msg_scheduler.md
Name: ctrl_msg_scheduler

Overview:
- Owns the control-message channel from the scheduler to the cores.
- Sequences core-reset commands: a full sweep at startup, plus sweeps or single-core resets requested by the host.
- Arbitrates reset commands against loopback descriptors, and holds back descriptors addressed to any core that has not yet acknowledged its reset.
- Sits between the loopback descriptor FIFO and the core control switch.

Parameters:
- CORE_COUNT, 16, number of cores; power of two, at least 2.
- DATA_WIDTH, 64, control message width.
- CORE_ID_WIDTH, $clog2(CORE_COUNT), core index width.
- LVL1_SW_PORTS, CORE_COUNT, first-level switch ports; LVL2 = CORE_COUNT/LVL1_SW_PORTS.
- STARTUP_RESET, 1, run a full sweep automatically after reset release.
- ACK_TIMEOUT, 4096, timeout in cycles; used only with the optional feature.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- host_cmd_valid  in  1  host command valid.
- host_cmd_ready  out  1  host command accepted.
- host_cmd_all  in  1  1 = reset all cores, 0 = reset the single core given by host_cmd_core.
- host_cmd_core  in  CORE_ID_WIDTH  target core for a single reset.
- lb_tdata  in  DATA_WIDTH  loopback descriptor.
- lb_tdest  in  CORE_ID_WIDTH  loopback destination core.
- lb_tvalid  in  1  loopback valid.
- lb_tready  out  1  loopback ready.
- core_ack_valid  in  1  a core reports reset complete.
- core_ack_core  in  CORE_ID_WIDTH  acknowledging core.
- ctrl_m_axis_tdata  out  DATA_WIDTH  message.
- ctrl_m_axis_tdest  out  CORE_ID_WIDTH  destination core.
- ctrl_m_axis_tvalid  out  1  message valid.
- ctrl_m_axis_tready  in  1  downstream ready.
- ctrl_m_axis_tlast  out  1  constant 1.
- reset_pending  out  CORE_COUNT  per-core flag: reset sent, acknowledgement outstanding.
- seq_busy  out  1  FSM is not in IDLE.
- timeout_err  out  1  sticky acknowledgement-timeout flag.

Behaviour:
- Reset values: all outputs 0, except ctrl_m_axis_tlast=1.
- After rst_n deasserts, the FSM enters SWEEP if STARTUP_RESET=1, otherwise IDLE.
- Output register:
  - Single entry; loads when (!ctrl_m_axis_tvalid || ctrl_m_axis_tready).
  - Data and dest stay stable while valid && !ready.
  - Latency is 1 cycle from load to valid.
- Reset message: tdata = 64'hFFFFFFFF_FFFFFFFE.
- Loopback message: tdata = {8'd0, lb_tdata[DATA_WIDTH-9:0]}, tdest = lb_tdest.
- FSM states:
  - IDLE:
    - Host command has priority over loopback.
    - host_cmd_ready = load-enable. On accept: host_cmd_all=1 → SWEEP with cnt=0; host_cmd_all=0 → SINGLE with the core index latched.
    - If no host command is present, the loopback is eligible: lb_tready = load-enable && !reset_pending[lb_tdest] && !host_cmd_valid.
    - A blocked loopback head stalls the loopback stream; there is no reordering.
  - SWEEP:
    - On each load, emit a reset message to reorder(cnt) and increment cnt.
    - reorder(c) = c if LVL2=1, else {c[LVL1_BITS-1:0], c[CORE_ID_WIDTH-1:LVL1_BITS]}.
    - After the load with cnt=CORE_COUNT-1, go to IDLE; cnt is CORE_ID_WIDTH+1 bits wide and must not wrap early.
  - SINGLE: one reset message to the latched core on load, then IDLE.
  - In SWEEP and SINGLE: lb_tready=0 and host_cmd_ready=0.
- reset_pending:
  - Bit i sets when a reset message for core i loads into the output register.
  - Bit i clears on core_ack_valid with core_ack_core=i.
  - If set and clear hit the same core in the same cycle, set wins.
  - An acknowledgement for a non-pending core is ignored.
- A single reset to a core that is already pending is re-sent and the bit stays set.
- seq_busy = (state != IDLE).
- Asserting rst_n mid-sweep aborts the sweep:
  - The output register, reset_pending and cnt all clear.
  - A new sweep starts after release if STARTUP_RESET=1.
- A message already valid is never dropped or altered by later arbitration.

Optional Feature:
- Macro: CTRL_SCHED_TIMEOUT_EN.
- When defined:
  - A counter increments while |reset_pending and restarts on any accepted acknowledgement.
  - When the counter reaches ACK_TIMEOUT-1 in IDLE: timeout_err sets, and the FSM enters SINGLE targeting the lowest-index pending core, with priority over host commands. The counter then restarts.
  - timeout_err clears on the next accepted host command.
- When undefined: no counter exists, timeout_err is tied to 0, and the FSM never self-triggers.

Test Plan:
- Startup with CORE_COUNT=16, LVL1_SW_PORTS=4, tready=1:
  - Expect 16 reset messages with dest order 0,4,8,12,1,5,…,15, then seq_busy=0 and reset_pending=16'hFFFF.
- Backpressure: tready low for 5 cycles mid-sweep:
  - tdata and tdest hold constant; no message is skipped or duplicated.
- Blocked loopback: acknowledge cores 0–14 only, then present lb_tdest=15 followed by a descriptor for dest 3:
  - lb_tready stays 0 until the acknowledgement for core 15 arrives.
  - Then dest 15 goes out, then dest 3, both with tdata[63:56]=0.
- Host priority: host_cmd_all=0, core 7 arrives in the same cycle as a valid loopback:
  - The reset to core 7 is emitted first; the loopback follows 1 cycle later if tready=1.
- Same-cycle set and clear: acknowledgement for core 2 in the same cycle as its reset load:
  - reset_pending[2] remains 1.
- Timeout (macro on, ACK_TIMEOUT=8, core 5 never acknowledges):
  - timeout_err=1 and a reset to core 5 is re-sent; a subsequent host command clears timeout_err.
